uart_tx_scheduler: RTL and testbench

- Shares the single UART byte transmitter (`Send`) between NUM_REQ message sources, such as the prompt, hint and answer printers of the guess-number game.
- Each source presents a packed message of up to MAX_BYTES bytes plus a length, and holds a request.
- The block arbitrates round-robin and serialises the winner's bytes MSB-byte-first.
- It paces `tx_vld` pulses BYTE_GAP cycles apart, because `Send` has no ready signal, then pulses a per-source `done`.

---
 rtl/uart_sched_pkg.sv | 25 ++
 rtl/rr_pick.sv | 33 +++
 rtl/uart_tx_scheduler.sv | 144 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler and the message printers.
package uart_sched_pkg;

    // Scheduler state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    // Default pacing: one byte slot must outlast a full UART frame
    localparam int unsigned BYTE_GAP_DEFAULT   = 12000;
    localparam int unsigned VLD_OFFSET_DEFAULT = 100;

    // Bits needed to count 0 .. gap-1 within one byte slot
    function automatic int unsigned cnt_width(input int unsigned gap);
        return (gap > 1) ? $clog2(gap) : 1;
    endfunction

    // Bits needed to index n sources (at least one bit)
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, with wrap.
module rr_pick
    import uart_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned PTR_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [PTR_W-1:0]   o_winner,
    output logic               o_any
);

    logic [PTR_W:0] w_pos;

    // Walk the sources in priority order starting at the pointer; keep the first hit
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_pos    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_pos = {1'b0, i_ptr} + (PTR_W+1)'(i);
            if (w_pos >= (PTR_W+1)'(NUM_REQ)) begin
                w_pos = w_pos - (PTR_W+1)'(NUM_REQ);
            end
            if (!o_any && i_req[w_pos[PTR_W-1:0]]) begin
                o_winner = w_pos[PTR_W-1:0];
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART byte transmitter between several message sources, round-robin,
// sending each latched message MSB-byte-first with fixed-length byte slots.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned MAX_BYTES  = 4,
    parameter int unsigned LEN_W      = 3,
    parameter int unsigned BYTE_GAP   = BYTE_GAP_DEFAULT,
    parameter int unsigned VLD_OFFSET = VLD_OFFSET_DEFAULT
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ*LEN_W-1:0]       i_req_len,
    input  logic [NUM_REQ*MAX_BYTES*8-1:0] i_req_data,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic [NUM_REQ-1:0]             o_done,
    output logic                           o_busy,
    output logic                           o_tx_vld,
    output logic [7:0]                     o_tx_data
);

    localparam int unsigned CNT_W = cnt_width(BYTE_GAP);
    localparam int unsigned PTR_W = idx_width(NUM_REQ);
    localparam int unsigned MSG_W = MAX_BYTES * 8;

    sched_state_e     r_state, w_state_d;
    logic [NUM_REQ-1:0] r_grant, w_grant_d;
    logic [PTR_W-1:0] r_ptr, w_ptr_d;
    logic [PTR_W-1:0] r_winner, w_winner_d;
    logic [MSG_W-1:0] r_msg, w_msg_d;
    logic [LEN_W-1:0] r_len, w_len_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [LEN_W-1:0] r_byte_idx, w_byte_idx_d;

    logic [PTR_W-1:0]   w_pick;
    logic               w_any;
    logic [LEN_W-1:0]   w_len_in;
    logic [MSG_W-1:0]   w_data_in;
    logic [NUM_REQ-1:0] w_pick_oh;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_winner (w_pick),
        .o_any    (w_any)
    );

    // Route the picked source's length and message onto common wires
    always_comb begin
        w_len_in  = '0;
        w_data_in = '0;
        w_pick_oh = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_pick == PTR_W'(i)) begin
                w_len_in     = i_req_len[i*LEN_W +: LEN_W];
                w_data_in    = i_req_data[i*MSG_W +: MSG_W];
                w_pick_oh[i] = 1'b1;
            end
        end
    end

    // Next-state logic: latch a winner in IDLE, pace byte slots in SEND, retire in DONE
    always_comb begin
        w_state_d    = r_state;
        w_grant_d    = r_grant;
        w_ptr_d      = r_ptr;
        w_winner_d   = r_winner;
        w_msg_d      = r_msg;
        w_len_d      = r_len;
        w_cnt_d      = r_cnt;
        w_byte_idx_d = r_byte_idx;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_d    = w_pick_oh;
                    w_winner_d   = w_pick;
                    w_msg_d      = w_data_in;
                    w_len_d      = (w_len_in > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : w_len_in;
                    w_cnt_d      = '0;
                    w_byte_idx_d = '0;
                    w_state_d    = (w_len_d == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                w_cnt_d = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(BYTE_GAP - 1)) begin
                    if (r_byte_idx == r_len - LEN_W'(1)) begin
                        w_state_d = DONE;
                    end else begin
                        // Shift so the next byte sits in the top position
                        w_byte_idx_d = r_byte_idx + LEN_W'(1);
                        w_cnt_d      = '0;
                        w_msg_d      = r_msg << 8;
                    end
                end
            end
            DONE: begin
                w_grant_d = '0;
                w_ptr_d   = (r_winner == PTR_W'(NUM_REQ - 1)) ? '0 : r_winner + PTR_W'(1);
                w_state_d = IDLE;
            end
            default: begin
                w_grant_d = '0;
                w_state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transfer in progress
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_ptr      <= '0;
            r_winner   <= '0;
            r_msg      <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_byte_idx <= '0;
        end else begin
            r_state    <= w_state_d;
            r_grant    <= w_grant_d;
            r_ptr      <= w_ptr_d;
            r_winner   <= w_winner_d;
            r_msg      <= w_msg_d;
            r_len      <= w_len_d;
            r_cnt      <= w_cnt_d;
            r_byte_idx <= w_byte_idx_d;
        end
    end

    // Outputs decoded from registers only, so they are clean at the clock edge
    assign o_grant   = r_grant;
    assign o_busy    = (r_state != IDLE);
    assign o_done    = (r_state == DONE) ? r_grant : '0;
    assign o_tx_vld  = (r_state == SEND) && (r_cnt == CNT_W'(VLD_OFFSET));
    assign o_tx_data = (r_state == SEND) ? r_msg[MSG_W-1 -: 8] : 8'h00;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with short byte slots (BYTE_GAP=20, VLD_OFFSET=2).
module tb_uart_tx_scheduler;

    localparam int unsigned NUM_REQ    = 3;
    localparam int unsigned MAX_BYTES  = 4;
    localparam int unsigned LEN_W      = 3;
    localparam int unsigned BYTE_GAP   = 20;
    localparam int unsigned VLD_OFFSET = 2;

    logic                           clk;
    logic                           rst_n;
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*LEN_W-1:0]       req_len;
    logic [NUM_REQ*MAX_BYTES*8-1:0] req_data;
    logic [NUM_REQ-1:0]             grant;
    logic [NUM_REQ-1:0]             done;
    logic                           busy;
    logic                           tx_vld;
    logic [7:0]                     tx_data;

    uart_tx_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .MAX_BYTES  (MAX_BYTES),
        .LEN_W      (LEN_W),
        .BYTE_GAP   (BYTE_GAP),
        .VLD_OFFSET (VLD_OFFSET)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_req_len  (req_len),
        .i_req_data (req_data),
        .o_grant    (grant),
        .o_done     (done),
        .o_busy     (busy),
        .o_tx_vld   (tx_vld),
        .o_tx_data  (tx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    int inv_err = 0;
    int vld_t[$];
    int vld_d[$];
    int done_t[$];
    int done_v[$];

    // Log strobes and done pulses mid-cycle; flag invariant breaks
    always @(negedge clk) begin
        if (tx_vld) begin
            vld_t.push_back(cyc);
            vld_d.push_back(int'(tx_data));
        end
        if (done != '0) begin
            done_t.push_back(cyc);
            done_v.push_back(int'(done));
        end
        if (($countones(grant) > 1) || ($countones(done) > 1) || (tx_vld && !busy)) begin
            inv_err++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick();
    endtask

    task automatic set_slot(input int i, input int len, input logic [31:0] data);
        req_len[i*LEN_W +: LEN_W] = LEN_W'(len);
        req_data[i*32 +: 32]      = data;
    endtask

    task automatic clear_logs();
        vld_t.delete();
        vld_d.delete();
        done_t.delete();
        done_v.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        clear_logs();
    endtask

    int t0;

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_len  = '0;
        req_data = '0;
        #2;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_vld", 32'(tx_vld), 32'h0);
        check("rst_data", 32'(tx_data), 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        clear_logs();

        // Single request, three bytes
        set_slot(0, 3, 32'h41424344);
        req = 3'b001;
        t0 = cyc;
        tick();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        req = 3'b000;
        wait_cyc(t0 + 62);
        check("t1_busy_low", 32'(busy), 32'h0);
        check("t1_nvld", 32'(vld_t.size()), 32'd3);
        check("t1_vld0_t", 32'(vld_t[0]), 32'(t0 + 3));
        check("t1_vld1_t", 32'(vld_t[1]), 32'(t0 + 23));
        check("t1_vld2_t", 32'(vld_t[2]), 32'(t0 + 43));
        check("t1_vld0_d", 32'(vld_d[0]), 32'h41);
        check("t1_vld1_d", 32'(vld_d[1]), 32'h42);
        check("t1_vld2_d", 32'(vld_d[2]), 32'h43);
        check("t1_ndone", 32'(done_t.size()), 32'd1);
        check("t1_done_t", 32'(done_t[0]), 32'(t0 + 61));
        check("t1_done_v", 32'(done_v[0]), 32'h1);

        // Simultaneous requests after reset: served 0, 1, 2, 0
        do_reset();
        set_slot(0, 1, 32'h11AABBCC);
        set_slot(1, 1, 32'h22AABBCC);
        set_slot(2, 1, 32'h33AABBCC);
        req = 3'b111;
        t0 = cyc;
        tick();
        check("t2_grant0", 32'(grant), 32'h1);
        wait_cyc(t0 + 23);
        check("t2_grant1", 32'(grant), 32'h2);
        wait_cyc(t0 + 45);
        check("t2_grant2", 32'(grant), 32'h4);
        wait_cyc(t0 + 88);
        req = 3'b000;
        check("t2_ndone", 32'(done_t.size()), 32'd4);
        check("t2_done0", {done_t[0][15:0], done_v[0][15:0]}, {16'(t0 + 21), 16'h1});
        check("t2_done1", {done_t[1][15:0], done_v[1][15:0]}, {16'(t0 + 43), 16'h2});
        check("t2_done2", {done_t[2][15:0], done_v[2][15:0]}, {16'(t0 + 65), 16'h4});
        check("t2_done3", {done_t[3][15:0], done_v[3][15:0]}, {16'(t0 + 87), 16'h1});
        check("t2_nvld", 32'(vld_t.size()), 32'd4);
        check("t2_vld_d", {vld_d[0][7:0], vld_d[1][7:0], vld_d[2][7:0], vld_d[3][7:0]},
              32'h11223311);
        check("t2_vld3_t", 32'(vld_t[3]), 32'(t0 + 69));
        wait_cyc(t0 + 92);
        clear_logs();

        // Zero length: immediate done, no strobe
        set_slot(1, 0, 32'hDEADBEEF);
        req = 3'b010;
        t0 = cyc;
        tick();
        req = 3'b000;
        wait_cyc(t0 + 4);
        check("t3_zero_ndone", 32'(done_t.size()), 32'd1);
        check("t3_zero_done", {done_t[0][15:0], done_v[0][15:0]}, {16'(t0 + 1), 16'h2});
        check("t3_zero_nvld", 32'(vld_t.size()), 32'd0);
        clear_logs();

        // Length 7 clamps to 4 bytes
        set_slot(2, 7, 32'hA1B2C3D4);
        req = 3'b100;
        t0 = cyc;
        tick();
        check("t3_clamp_grant", 32'(grant), 32'h4);
        req = 3'b000;
        wait_cyc(t0 + 84);
        check("t3_clamp_nvld", 32'(vld_t.size()), 32'd4);
        check("t3_clamp_data", {vld_d[0][7:0], vld_d[1][7:0], vld_d[2][7:0], vld_d[3][7:0]},
              32'hA1B2C3D4);
        check("t3_clamp_vld3_t", 32'(vld_t[3]), 32'(t0 + 63));
        check("t3_clamp_done", {done_t[0][15:0], done_v[0][15:0]}, {16'(t0 + 81), 16'h4});
        clear_logs();

        // Inputs change during byte 0: latched message still used
        set_slot(0, 2, 32'h5A6B7C8D);
        req = 3'b001;
        t0 = cyc;
        tick();
        wait_cyc(t0 + 3);
        set_slot(0, 4, 32'hFFFFFFFF);
        req = 3'b000;
        wait_cyc(t0 + 45);
        check("t4_nvld", 32'(vld_t.size()), 32'd2);
        check("t4_data", {vld_d[0][7:0], vld_d[1][7:0]}, 32'h5A6B);
        check("t4_done", {done_t[0][15:0], done_v[0][15:0]}, {16'(t0 + 41), 16'h1});
        clear_logs();

        // Reset at cnt=5 of byte 1 aborts the transfer
        set_slot(0, 3, 32'h01020304);
        req = 3'b001;
        t0 = cyc;
        tick();
        check("t5_grant", 32'(grant), 32'h1);
        req = 3'b000;
        wait_cyc(t0 + 26);
        check("t5_pre_nvld", 32'(vld_t.size()), 32'd2);
        check("t5_pre_busy", 32'(busy), 32'h1);
        clear_logs();
        rst_n = 1'b0;
        #1;
        check("t5_rst_outs", {29'(grant), done, busy, tx_vld, tx_data}, 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (60) tick();
        check("t5_post_nvld", 32'(vld_t.size()), 32'd0);
        check("t5_post_ndone", 32'(done_t.size()), 32'd0);
        // Pointer back at 0: source 0 beats source 2
        set_slot(0, 1, 32'h66000000);
        set_slot(2, 1, 32'h99000000);
        req = 3'b101;
        t0 = cyc;
        tick();
        check("t5_ptr_grant", 32'(grant), 32'h1);
        req = 3'b000;
        wait_cyc(t0 + 25);
        check("t5_ptr_done", {done_t[0][15:0], done_v[0][15:0]}, {16'(t0 + 21), 16'h1});
        clear_logs();

        // Fairness: held req0 yields to req2 that arrived mid-transfer
        set_slot(0, 1, 32'h77000000);
        set_slot(2, 1, 32'h88000000);
        req = 3'b001;
        t0 = cyc;
        tick();
        check("t6_grant0", 32'(grant), 32'h1);
        wait_cyc(t0 + 5);
        req = 3'b101;
        wait_cyc(t0 + 23);
        check("t6_grant2", 32'(grant), 32'h4);
        req = 3'b001;
        wait_cyc(t0 + 45);
        check("t6_grant0_again", 32'(grant), 32'h1);
        req = 3'b000;
        wait_cyc(t0 + 70);
        check("t6_ndone", 32'(done_t.size()), 32'd3);
        check("t6_done_v", {done_v[0][7:0], done_v[1][7:0], done_v[2][7:0]}, 32'h010401);
        check("t6_vld_d", {vld_d[0][7:0], vld_d[1][7:0], vld_d[2][7:0]}, 32'h778877);

        check("invariants", 32'(inv_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
